// File: rtl/iomem_pkg.sv
// Shared widths, FSM state encoding and command word layout for the iomem initiator.
package iomem_pkg;

   localparam int IOMEM_ADDR_W = 32;
   localparam int IOMEM_DATA_W = 32;
   localparam int IOMEM_STRB_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RSP  = 2'd2
   } iomem_state_t;

   // 68-bit FIFO word: {wstrb, wdata, addr}
   typedef struct packed {
      logic [IOMEM_STRB_W-1:0] wstrb;
      logic [IOMEM_DATA_W-1:0] wdata;
      logic [IOMEM_ADDR_W-1:0] addr;
   } iomem_cmd_t;

endpackage

// File: rtl/iomem_cmd_fifo.sv
// Synchronous command FIFO; full/empty come from the registered count only,
// so a same-cycle pop never frees space for a push in that cycle.
module iomem_cmd_fifo
   import iomem_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  iomem_cmd_t               din,
   input  logic                     pop,
   output iomem_cmd_t               dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   iomem_cmd_t      mem [DEPTH];
   logic [AW-1:0]   wptr;
   logic [AW-1:0]   rptr;
   logic            do_push;
   logic            do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= din;
   end

endmodule

// File: rtl/iomem_initiator.sv
// PicoSoC iomem bus master: queued commands in, one bus access at a time, response out.
// Optional statistics counters enabled by defining IOMEM_INIT_STATS_EN.
module iomem_initiator
   import iomem_pkg::*;
#(
   parameter int CMD_DEPTH      = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [IOMEM_ADDR_W-1:0] cmd_addr,
   input  logic [IOMEM_DATA_W-1:0] cmd_wdata,
   input  logic [IOMEM_STRB_W-1:0] cmd_wstrb,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [IOMEM_DATA_W-1:0] rsp_rdata,
   output logic                    rsp_err,
   output logic                    rsp_write,
   output logic                    iomem_valid,
   input  logic                    iomem_ready,
   output logic [IOMEM_STRB_W-1:0] iomem_wstrb,
   output logic [IOMEM_ADDR_W-1:0] iomem_addr,
   output logic [IOMEM_DATA_W-1:0] iomem_wdata,
   input  logic [IOMEM_DATA_W-1:0] iomem_rdata,
   output logic                    busy,
   output logic [15:0]             stat_done,
   output logic [15:0]             stat_tmo
);

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   iomem_state_t                  state;
   logic [15:0]                   tmo_cnt;
   iomem_cmd_t                    cmd_in;
   iomem_cmd_t                    head;
   logic                          fifo_full;
   logic                          fifo_empty;
   logic [$clog2(CMD_DEPTH):0]    fifo_count;
   logic                          pop;
   logic                          timeout_hit;
   logic                          rsp_hs;

   assign cmd_in      = '{wstrb: cmd_wstrb, wdata: cmd_wdata, addr: cmd_addr};
   assign cmd_ready   = !fifo_full;
   assign pop         = (state == ST_IDLE) && !fifo_empty;
   assign busy        = (state != ST_IDLE) || (fifo_count != '0);
   assign timeout_hit = (state == ST_REQ) && !iomem_ready && (tmo_cnt == TMO_LAST);
   assign rsp_hs      = (state == ST_RSP) && rsp_ready;

   iomem_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (cmd_valid),
      .din   (cmd_in),
      .pop   (pop),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         tmo_cnt     <= '0;
         iomem_valid <= 1'b0;
         iomem_addr  <= '0;
         iomem_wdata <= '0;
         iomem_wstrb <= '0;
         rsp_valid   <= 1'b0;
         rsp_err     <= 1'b0;
         rsp_rdata   <= '0;
         rsp_write   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  iomem_valid <= 1'b1;
                  iomem_addr  <= head.addr;
                  iomem_wdata <= head.wdata;
                  iomem_wstrb <= head.wstrb;
                  tmo_cnt     <= '0;
                  state       <= ST_REQ;
               end
            end
            ST_REQ: begin
               // ready takes priority over a timeout landing on the same edge
               if (iomem_ready) begin
                  rsp_rdata   <= (iomem_wstrb == '0) ? iomem_rdata : '0;
                  rsp_err     <= 1'b0;
                  rsp_write   <= |iomem_wstrb;
                  rsp_valid   <= 1'b1;
                  iomem_valid <= 1'b0;
                  state       <= ST_RSP;
               end else if (timeout_hit) begin
                  rsp_rdata   <= '0;
                  rsp_err     <= 1'b1;
                  rsp_write   <= |iomem_wstrb;
                  rsp_valid   <= 1'b1;
                  iomem_valid <= 1'b0;
                  state       <= ST_RSP;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            ST_RSP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef IOMEM_INIT_STATS_EN
   logic [15:0] done_q;
   logic [15:0] tmo_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         done_q <= '0;
         tmo_q  <= '0;
      end else begin
         if (rsp_hs && done_q != 16'hFFFF)      done_q <= done_q + 1'b1;
         if (timeout_hit && tmo_q != 16'hFFFF)  tmo_q  <= tmo_q + 1'b1;
      end
   end

   assign stat_done = done_q;
   assign stat_tmo  = tmo_q;
`else
   logic unused_stats;
   assign unused_stats = rsp_hs;
   assign stat_done    = '0;
   assign stat_tmo     = '0;
`endif

endmodule

// File: tb/tb_iomem_initiator.sv
// Directed bench for iomem_initiator with a small GPIO-style responder model.
module tb_iomem_initiator;

   localparam int TMO = 8;

   logic        clk;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        rsp_write;
   logic        iomem_valid;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb;
   logic [31:0] iomem_addr;
   logic [31:0] iomem_wdata;
   logic [31:0] iomem_rdata;
   logic        busy;
   logic [15:0] stat_done;
   logic [15:0] stat_tmo;

   iomem_initiator #(.CMD_DEPTH(4), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_write(rsp_write),
      .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
      .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
      .busy(busy), .stat_done(stat_done), .stat_tmo(stat_tmo)
   );

   always #5 clk = ~clk;

   // Responder: mode 0 = ready the cycle after valid, 1 = never, 2 = ready on the timeout edge
   int          mode;
   int          vcnt;
   logic [15:0] gpio;
   logic [15:0] sw;
   assign iomem_rdata = {sw, gpio};

   always @(posedge clk) begin
      if (reset) begin
         iomem_ready <= 1'b0;
         vcnt        <= 0;
         gpio        <= 16'h0000;
      end else if (iomem_valid && !iomem_ready) begin
         vcnt        <= vcnt + 1;
         iomem_ready <= (mode == 0 && vcnt == 0) || (mode == 2 && vcnt == TMO - 2);
      end else begin
         if (iomem_valid && iomem_ready) begin
            if (iomem_wstrb[0]) gpio[7:0]  <= iomem_wdata[7:0];
            if (iomem_wstrb[1]) gpio[15:8] <= iomem_wdata[15:8];
         end
         iomem_ready <= 1'b0;
         vcnt        <= 0;
      end
   end

   // Bus/response monitor
   int          vh_tot;
   int          iss_tot;
   int          rsp_tot;
   logic        prev_v;
   logic [31:0] addr_log [64];

   always @(negedge clk) begin
      if (iomem_valid) vh_tot <= vh_tot + 1;
      if (iomem_valid && !prev_v) begin
         addr_log[iss_tot % 64] <= iomem_addr;
         iss_tot <= iss_tot + 1;
      end
      prev_v <= iomem_valid;
      if (rsp_valid && rsp_ready) rsp_tot <= rsp_tot + 1;
   end

   int checks;
   int errors;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      int n;
      cmd_addr  = a;
      cmd_wdata = d;
      cmd_wstrb = s;
      cmd_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("push_wait", 32'(n < 200), 32'd1);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp();
      int n;
      n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("rsp_wait", 32'(n < 100), 32'd1);
      #1;
   endtask

   task automatic handshake();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   int vh0;
   int iss0;
   int rsp0;
   int n;

   initial begin
      clk = 0; reset = 1; cmd_valid = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
      rsp_ready = 0; mode = 0; sw = 16'h1234;
      vh_tot = 0; iss_tot = 0; rsp_tot = 0; prev_v = 0;
      checks = 0; errors = 0;
      repeat (3) tick();
      reset = 0;
      @(negedge clk);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_iomem_valid", 32'(iomem_valid), 32'd0);
      chk("rst_iomem_addr", iomem_addr, 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_stat_done", 32'(stat_done), 32'd0);
      tick();

      // full-word write
      vh0 = vh_tot;
      push(32'h0300_0000, 32'h0000_A5A5, 4'hF);
      wait_rsp();
      chk("wr_valid_cycles", 32'(vh_tot - vh0), 32'd2);
      chk("wr_rsp_write", 32'(rsp_write), 32'd1);
      chk("wr_rsp_err", 32'(rsp_err), 32'd0);
      chk("wr_rsp_rdata", rsp_rdata, 32'd0);
      chk("wr_gpio", 32'(gpio), 32'h0000_A5A5);
      handshake();

      // read back
      push(32'h0300_0000, 32'h0, 4'h0);
      wait_rsp();
      chk("rd_rdata", rsp_rdata, 32'h1234_A5A5);
      chk("rd_rsp_write", 32'(rsp_write), 32'd0);
      chk("rd_rsp_err", 32'(rsp_err), 32'd0);
      handshake();

      // byte-lane write
      push(32'h0300_0000, 32'h0000_3C00, 4'b0010);
      wait_rsp();
      chk("bw_gpio", 32'(gpio), 32'h0000_3CA5);
      handshake();

      // timeout, then a queued command completes normally
      mode = 1;
      vh0 = vh_tot;
      push(32'h0300_0004, 32'h0, 4'h0);
      push(32'h0300_0000, 32'h0, 4'h0);
      wait_rsp();
      chk("tmo_valid_cycles", 32'(vh_tot - vh0), 32'd8);
      chk("tmo_rsp_err", 32'(rsp_err), 32'd1);
      chk("tmo_rsp_rdata", rsp_rdata, 32'd0);
      chk("tmo_iomem_valid", 32'(iomem_valid), 32'd0);
      mode = 0;
      handshake();
      wait_rsp();
      chk("tmo_next_err", 32'(rsp_err), 32'd0);
      chk("tmo_next_rdata", rsp_rdata, 32'h1234_3CA5);
      handshake();
`ifdef IOMEM_INIT_STATS_EN
      chk("stat_tmo_1", 32'(stat_tmo), 32'd1);
`else
      chk("stat_tmo_off", 32'(stat_tmo), 32'd0);
`endif

      // back-pressure: fill FIFO while first response is held
      iss0 = iss_tot;
      rsp0 = rsp_tot;
      for (int i = 0; i < 5; i++) push(32'h0300_0100 + 32'(i * 4), 32'h0, 4'h0);
      @(negedge clk);
      chk("bp_cmd_ready_low", 32'(cmd_ready), 32'd0);
      repeat (5) @(negedge clk);
      #1;
      chk("bp_single_issue", 32'(iss_tot - iss0), 32'd1);
      chk("bp_iomem_valid", 32'(iomem_valid), 32'd0);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      tick();
      rsp_ready = 1'b1;
      push(32'h0300_0114, 32'h0, 4'h0);
      n = 0;
      while ((rsp_tot - rsp0) < 6 && n < 300) begin
         @(negedge clk);
         n++;
      end
      #1;
      chk("bp_drain_done", 32'(n < 300), 32'd1);
      tick();
      rsp_ready = 1'b0;
      chk("bp_issue_count", 32'(iss_tot - iss0), 32'd6);
      for (int i = 0; i < 6; i++)
         chk($sformatf("bp_addr%0d", i), addr_log[(iss0 + i) % 64], 32'h0300_0100 + 32'(i * 4));

      // ready arriving exactly on the timeout edge wins
      mode = 2;
      sw = 16'hBEEF;
      vh0 = vh_tot;
      push(32'h0300_0000, 32'h0, 4'h0);
      wait_rsp();
      chk("edge_valid_cycles", 32'(vh_tot - vh0), 32'd8);
      chk("edge_rsp_err", 32'(rsp_err), 32'd0);
      chk("edge_rsp_rdata", rsp_rdata, 32'hBEEF_3CA5);
      handshake();
      @(negedge clk);
`ifdef IOMEM_INIT_STATS_EN
      chk("stat_done_12", 32'(stat_done), 32'd12);
      chk("stat_tmo_still1", 32'(stat_tmo), 32'd1);
`else
      chk("stat_done_off", 32'(stat_done), 32'd0);
`endif
      chk("idle_busy", 32'(busy), 32'd0);
      tick();

      // reset while a request is outstanding and another is queued
      mode = 1;
      push(32'h0300_0200, 32'h0, 4'h0);
      push(32'h0300_0204, 32'h0, 4'h0);
      repeat (3) tick();
      chk("pre_rst_valid", 32'(iomem_valid), 32'd1);
      reset = 1'b1;
      cmd_valid = 1'b1;
      cmd_addr = 32'h0300_0300;
      tick();
      reset = 1'b0;
      cmd_valid = 1'b0;
      mode = 0;
      @(negedge clk);
      chk("mid_rst_iomem_valid", 32'(iomem_valid), 32'd0);
      chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_stat_done", 32'(stat_done), 32'd0);
      #1;
      iss0 = iss_tot;
      repeat (10) @(negedge clk);
      #1;
      chk("post_rst_no_issue", 32'(iss_tot - iss0), 32'd0);
      chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
